// File: rtl/axi_aw_write_arbiter.sv
// Two-master, single-outstanding AXI write arbiter: round-robin AW grant,
// W beats routed from the granted master, B response steered back by ID tag.
module axi_aw_write_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ID_W-1:0]       m0_awid,
  input  logic [ADDR_W-1:0]     m0_awaddr,
  input  logic [LEN_W-1:0]      m0_awlen,
  input  logic [2:0]            m0_awsize,
  input  logic [1:0]            m0_awburst,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic                  m0_wlast,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [ID_W-1:0]       m0_bid,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,
  input  logic [ID_W-1:0]       m1_awid,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [LEN_W-1:0]      m1_awlen,
  input  logic [2:0]            m1_awsize,
  input  logic [1:0]            m1_awburst,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [ID_W-1:0]       m1_bid,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [ID_W+3:0]       s_awid,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [LEN_W-1:0]      s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [ID_W+3:0]       s_bid,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic                  err_wlast
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_rr_last;
  logic [LEN_W-1:0] r_beat_cnt;

  logic       w_req, w_grant_c, w_aw_hs;
  logic       w_in_data, w_in_resp, w_w_hs, w_b_hs, w_mg_wlast;
  logic [3:0] w_tag;

  // Tie goes to the master that did not win last time.
  assign w_req     = m0_awvalid | m1_awvalid;
  assign w_grant_c = (m0_awvalid & m1_awvalid) ? ~r_rr_last : m1_awvalid;
  assign w_aw_hs   = (r_state == IDLE) & w_req;

  assign m0_awready = w_aw_hs & ~w_grant_c;
  assign m1_awready = w_aw_hs &  w_grant_c;

  assign w_in_data = (r_state == DATA);
  assign w_in_resp = (r_state == RESP);

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    s_wdata    = r_grant ? m1_wdata  : m0_wdata;
    s_wstrb    = r_grant ? m1_wstrb  : m0_wstrb;
    s_wvalid   = w_in_data & (r_grant ? m1_wvalid : m0_wvalid);
    w_mg_wlast = r_grant ? m1_wlast  : m0_wlast;
  end

  // Framing comes from the beat counter, not from the master's wlast.
  assign s_wlast   = w_in_data & (r_beat_cnt == s_awlen);
  assign m0_wready = w_in_data & ~r_grant & s_wready;
  assign m1_wready = w_in_data &  r_grant & s_wready;
  assign w_w_hs    = s_wvalid & s_wready;

  assign w_tag     = s_bid[ID_W+3:ID_W];
  assign m0_bvalid = w_in_resp & s_bvalid & (w_tag == 4'd0);
  assign m1_bvalid = w_in_resp & s_bvalid & (w_tag == 4'd1);
  assign m0_bid    = s_bid[ID_W-1:0];
  assign m1_bid    = s_bid[ID_W-1:0];
  assign m0_bresp  = s_bresp;
  assign m1_bresp  = s_bresp;
  // Responses carrying an unknown tag are sunk so the FSM cannot stall.
  assign s_bready  = w_in_resp & ((w_tag == 4'd0) ? m0_bready :
                                  (w_tag == 4'd1) ? m1_bready : 1'b1);
  assign w_b_hs    = s_bvalid & s_bready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_beat_cnt <= '0;
      s_awid     <= '0;
      s_awaddr   <= '0;
      s_awlen    <= '0;
      s_awsize   <= '0;
      s_awburst  <= '0;
      s_awvalid  <= 1'b0;
      err_wlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          s_awid     <= {3'b000, w_grant_c, (w_grant_c ? m1_awid : m0_awid)};
          s_awaddr   <= w_grant_c ? m1_awaddr  : m0_awaddr;
          s_awlen    <= w_grant_c ? m1_awlen   : m0_awlen;
          s_awsize   <= w_grant_c ? m1_awsize  : m0_awsize;
          s_awburst  <= w_grant_c ? m1_awburst : m0_awburst;
          s_awvalid  <= 1'b1;
          r_grant    <= w_grant_c;
          r_rr_last  <= w_grant_c;
          r_beat_cnt <= '0;
          r_state    <= ADDR;
        end
        ADDR: if (s_awready) begin
          s_awvalid <= 1'b0;
          r_state   <= DATA;
        end
        DATA: if (w_w_hs) begin
          r_beat_cnt <= r_beat_cnt + LEN_W'(1);
          if (w_mg_wlast != s_wlast) err_wlast <= 1'b1;
          if (s_wlast) r_state <= RESP;
        end
        RESP: if (w_b_hs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_write_arbiter.sv
// Directed bench for axi_aw_write_arbiter: arbitration, AW hold, burst framing,
// wlast error flag, B routing and mid-burst reset.
module tb_axi_aw_write_arbiter;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4;

  logic clock = 1'b0, reset;
  logic [ID_W-1:0] m0_awid, m1_awid, m0_bid, m1_bid;
  logic [ADDR_W-1:0] m0_awaddr, m1_awaddr, s_awaddr;
  logic [LEN_W-1:0] m0_awlen, m1_awlen, s_awlen;
  logic [2:0] m0_awsize, m1_awsize, s_awsize;
  logic [1:0] m0_awburst, m1_awburst, s_awburst, m0_bresp, m1_bresp, s_bresp;
  logic m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, s_wdata;
  logic [DATA_W/8-1:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [ID_W+3:0] s_awid, s_bid;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready, err_wlast;

  int n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  axi_aw_write_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
    .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
    .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready),
    .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
    .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .err_wlast(err_wlast)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // In IDLE: expect master g to be granted, then take the handshake edge.
  task automatic aw_handshake(input int g);
    settle();
    check("awready_m0", m0_awready, (g == 0));
    check("awready_m1", m1_awready, (g == 1));
    tick();
  endtask

  task automatic addr_phase(input int g, input logic [ID_W-1:0] id);
    settle();
    check("awvalid_up", s_awvalid, 1);
    check("awid", s_awid, {4'(g), id});
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    settle();
    check("awvalid_down", s_awvalid, 0);
  endtask

  // Drive n beats from master g; bad_beat flips that beat's master wlast.
  task automatic beats(input int g, input int n, input bit toggle, input int bad_beat);
    int cnt = 0, cyc = 0;
    while (cnt < n && cyc < 40) begin
      if (g == 0) begin
        m0_wvalid = 1'b1; m0_wdata = 32'hD000 + cnt; m0_wlast = (cnt == n - 1) ^ (cnt == bad_beat);
      end else begin
        m1_wvalid = 1'b1; m1_wdata = 32'hE000 + cnt; m1_wlast = (cnt == n - 1) ^ (cnt == bad_beat);
      end
      s_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      settle();
      check("wvalid", s_wvalid, 1);
      check("wdata", s_wdata, (g == 0 ? 32'hD000 : 32'hE000) + cnt);
      check("wlast", s_wlast, (cnt == n - 1));
      check("wready_other", (g == 0) ? m1_wready : m0_wready, 0);
      check("wready_grant", (g == 0) ? m0_wready : m1_wready, s_wready);
      if (s_wready) cnt++;
      tick();
      cyc++;
    end
    if (cnt < n) check("beat_budget", cnt, n);
    m0_wvalid = 1'b0; m1_wvalid = 1'b0; m0_wlast = 1'b0; m1_wlast = 1'b0; s_wready = 1'b0;
    settle();
    check("wvalid_after_burst", s_wvalid, 0);
  endtask

  task automatic b_phase(input int g, input logic [ID_W-1:0] id, input logic [3:0] tag);
    s_bvalid = 1'b1; s_bid = {tag, id}; s_bresp = 2'b10;
    m0_bready = (tag == 4'd0); m1_bready = (tag == 4'd1);
    settle();
    check("bvalid_m0", m0_bvalid, (tag == 4'd0));
    check("bvalid_m1", m1_bvalid, (tag == 4'd1));
    check("s_bready", s_bready, 1);
    if (tag <= 4'd1) begin
      check("bid", (g == 0) ? m0_bid : m1_bid, id);
      check("bresp", (g == 0) ? m0_bresp : m1_bresp, 2'b10);
    end
    tick();
    s_bvalid = 1'b0; m0_bready = 1'b0; m1_bready = 1'b0;
    settle();
    check("s_bready_idle", s_bready, 0);
  endtask

  initial begin
    reset = 1'b1;
    m0_awid = '0; m0_awaddr = '0; m0_awlen = '0; m0_awsize = 3'd2; m0_awburst = 2'd1; m0_awvalid = 0;
    m1_awid = '0; m1_awaddr = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'd1; m1_awvalid = 0;
    m0_wdata = '0; m0_wstrb = 4'hF; m0_wlast = 0; m0_wvalid = 0; m0_bready = 0;
    m1_wdata = '0; m1_wstrb = 4'hF; m1_wlast = 0; m1_wvalid = 0; m1_bready = 0;
    s_awready = 0; s_wready = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_awvalid", s_awvalid, 0);
    check("rst_awid", s_awid, 0);
    check("rst_awaddr", s_awaddr, 0);
    check("rst_wvalid", s_wvalid, 0);
    check("rst_bready", s_bready, 0);
    check("rst_err", err_wlast, 0);
    check("rst_awready", m0_awready, 0);

    // Single m0 request
    m0_awvalid = 1'b1; m0_awaddr = 32'h1000_0000; m0_awlen = 4'd0; m0_awid = 4'd3;
    aw_handshake(0);
    m0_awvalid = 1'b0;
    settle();
    check("t1_awaddr", s_awaddr, 32'h1000_0000);
    check("t1_awlen", s_awlen, 0);
    addr_phase(0, 4'd3);
    beats(0, 1, 1'b0, -1);
    b_phase(0, 4'd3, 4'd0);
    check("t1_err", err_wlast, 0);

    // Round-robin with both masters requesting continuously from reset
    reset = 1'b1; tick(); reset = 1'b0;
    m0_awvalid = 1'b1; m0_awid = 4'h5; m0_awaddr = 32'h2000_0000; m0_awlen = 4'd0;
    m1_awvalid = 1'b1; m1_awid = 4'hA; m1_awaddr = 32'h3000_0000; m1_awlen = 4'd0;
    aw_handshake(0); addr_phase(0, 4'h5); beats(0, 1, 1'b0, -1); b_phase(0, 4'h5, 4'd0);
    aw_handshake(1); addr_phase(1, 4'hA); beats(1, 1, 1'b0, -1); b_phase(1, 4'hA, 4'd1);
    aw_handshake(0);
    m0_awvalid = 1'b0; m1_awvalid = 1'b0;

    // Third transaction: s_awready held low for 5 cycles
    m0_wvalid = 1'b1; s_wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("hold_awvalid", s_awvalid, 1);
      check("hold_awaddr", s_awaddr, 32'h2000_0000);
      check("hold_awid", s_awid, 8'h05);
      check("hold_no_w", s_wvalid, 0);
      check("hold_no_wready", m0_wready, 0);
      tick();
    end
    m0_wvalid = 1'b0; s_wready = 1'b0;
    addr_phase(0, 4'h5); beats(0, 1, 1'b0, -1); b_phase(0, 4'h5, 4'd0);

    // m1 len-3 burst with toggling s_wready
    m1_awvalid = 1'b1; m1_awid = 4'h2; m1_awaddr = 32'h4000_0040; m1_awlen = 4'd3;
    aw_handshake(1);
    m1_awvalid = 1'b0;
    settle();
    check("t4_awlen", s_awlen, 3);
    addr_phase(1, 4'h2); beats(1, 4, 1'b1, -1); b_phase(1, 4'h2, 4'd1);
    check("t4_err", err_wlast, 0);

    // m0 len-1 burst with early master wlast
    m0_awvalid = 1'b1; m0_awid = 4'h9; m0_awlen = 4'd1;
    aw_handshake(0);
    m0_awvalid = 1'b0;
    addr_phase(0, 4'h9); beats(0, 2, 1'b0, 0);
    check("t5_err_set", err_wlast, 1);
    b_phase(0, 4'h9, 4'd0);
    check("t5_err_sticky", err_wlast, 1);

    // Reset in DATA after two beats of a len-3 burst
    m0_awvalid = 1'b1; m0_awid = 4'h1; m0_awlen = 4'd3;
    aw_handshake(0);
    m0_awvalid = 1'b0;
    addr_phase(0, 4'h1);
    m0_wvalid = 1'b1; s_wready = 1'b1; m0_wlast = 1'b0;
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    settle();
    check("mid_awvalid", s_awvalid, 0);
    check("mid_wvalid", s_wvalid, 0);
    check("mid_wready", m0_wready, 0);
    check("mid_bready", s_bready, 0);
    check("mid_err", err_wlast, 0);
    check("mid_awid", s_awid, 0);
    m0_wvalid = 1'b0; s_wready = 1'b0;
    m1_awvalid = 1'b1; m1_awid = 4'h7; m1_awlen = 4'd0;
    aw_handshake(1);
    m1_awvalid = 1'b0;
    addr_phase(1, 4'h7); beats(1, 1, 1'b0, -1);
    // Unknown tag 2 is sunk without any master bvalid
    b_phase(1, 4'h7, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
